// File: rtl/ascii_ps2_tx_if.sv
// ascii_ps2_tx_if: character handshake between a character source and the
// PS/2 keyboard emulator.
//   in_valid : source holds a character on ascii
//   ascii    : ASCII code to transmit
//   in_ready : emulator is idle and will accept on the next rising edge
interface ascii_ps2_tx_if;
    logic       in_valid;
    logic [7:0] ascii;
    logic       in_ready;

    modport master (
        output in_valid,
        output ascii,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  ascii,
        output in_ready
    );
endinterface

// File: rtl/ascii_ps2_tx.sv
// ascii_ps2_tx: device-side PS/2 keyboard emulator. Takes one ASCII character
// per valid/ready handshake and plays the matching Set-2 make/break sequence
// (wrapped in Left-Shift make/break for uppercase) as 11-bit PS/2 frames,
// driving ps2_clk/ps2_data the way a keyboard would.
//
// Ports:
//   clk      : system clock, rising edge
//   clrn     : synchronous active-low reset
//   bus      : slave side of the character handshake (in_valid, ascii, in_ready)
//   ps2_clk  : PS/2 clock, idle high, registered
//   ps2_data : PS/2 data, idle high, registered
//   busy     : a character sequence is in progress
//   tx_done  : one-cycle pulse on the last GAP cycle of the last frame
//   err      : one-cycle pulse after an unsupported ASCII code is accepted
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | lines high, in_ready=1, waiting for a character
// S_BIT_HI| ps2_clk high for HALF cycles; ps2_data changed on entry
// S_BIT_LO| ps2_clk low for HALF cycles; host samples on the falling edge
// S_GAP   | both lines high for GAP cycles after every frame
module ascii_ps2_tx #(
    parameter int HALF = 2500,
    parameter int GAP  = 5000
) (
    input  logic clk,
    input  logic clrn,
    ascii_ps2_tx_if.slave bus,
    output logic ps2_clk,
    output logic ps2_data,
    output logic busy,
    output logic tx_done,
    output logic err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BIT_HI = 2'd1;
    localparam logic [1:0] S_BIT_LO = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int CNT_MAX = (HALF > GAP) ? HALF : GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(GAP - 1);

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    frame_idx;
    logic [7:0]    code_q;
    logic          shift_q;

    // ASCII -> scancode lookup; uppercase letters fold onto lowercase
    logic       lk_upper;
    logic [7:0] lk_char;
    logic [7:0] lk_code;
    logic       lk_ok;

    assign lk_upper = (bus.ascii >= 8'h41) && (bus.ascii <= 8'h5A);
    assign lk_char  = lk_upper ? (bus.ascii | 8'h20) : bus.ascii;

    always_comb begin
        lk_ok   = 1'b1;
        lk_code = 8'h00;
        case (lk_char)
            8'h61: lk_code = 8'h1C;
            8'h62: lk_code = 8'h32;
            8'h63: lk_code = 8'h21;
            8'h64: lk_code = 8'h23;
            8'h65: lk_code = 8'h24;
            8'h66: lk_code = 8'h2B;
            8'h67: lk_code = 8'h34;
            8'h68: lk_code = 8'h33;
            8'h69: lk_code = 8'h43;
            8'h6A: lk_code = 8'h3B;
            8'h6B: lk_code = 8'h42;
            8'h6C: lk_code = 8'h4B;
            8'h6D: lk_code = 8'h3A;
            8'h6E: lk_code = 8'h31;
            8'h6F: lk_code = 8'h44;
            8'h70: lk_code = 8'h4D;
            8'h71: lk_code = 8'h15;
            8'h72: lk_code = 8'h2D;
            8'h73: lk_code = 8'h1B;
            8'h74: lk_code = 8'h2C;
            8'h75: lk_code = 8'h3C;
            8'h76: lk_code = 8'h2A;
            8'h77: lk_code = 8'h1D;
            8'h78: lk_code = 8'h22;
            8'h79: lk_code = 8'h35;
            8'h7A: lk_code = 8'h1A;
            8'h30: lk_code = 8'h45;
            8'h31: lk_code = 8'h16;
            8'h32: lk_code = 8'h1E;
            8'h33: lk_code = 8'h26;
            8'h34: lk_code = 8'h25;
            8'h35: lk_code = 8'h2E;
            8'h36: lk_code = 8'h36;
            8'h37: lk_code = 8'h3D;
            8'h38: lk_code = 8'h3E;
            8'h39: lk_code = 8'h46;
            8'h20: lk_code = 8'h29;
            8'h0A: lk_code = 8'h5A;
            8'h0D: lk_code = 8'h5A;
            8'h08: lk_code = 8'h66;
            default: lk_ok = 1'b0;
        endcase
    end

    // Byte carried by the current frame, derived from the latched code/shift
    logic [7:0]  cur_byte;
    logic        last_frame;
    logic [10:0] frame_word;
    logic [3:0]  next_bit;

    always_comb begin
        cur_byte = code_q;
        if (shift_q) begin
            case (frame_idx)
                3'd0, 3'd5: cur_byte = SC_LSHIFT;
                3'd2, 3'd4: cur_byte = SC_BREAK;
                default:    cur_byte = code_q;
            endcase
        end else if (frame_idx == 3'd1) begin
            cur_byte = SC_BREAK;
        end
    end

    assign last_frame = shift_q ? (frame_idx == 3'd5) : (frame_idx == 3'd2);
    // stop, odd parity, data LSB first, start: index = bit number in the frame
    assign frame_word = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    assign next_bit   = bit_idx + 4'd1;

    assign bus.in_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign tx_done      = (state == S_GAP) && (cnt == GAP_TC) && last_frame;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_idx <= '0;
            code_q    <= '0;
            shift_q   <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (bus.in_valid) begin
                        if (lk_ok) begin
                            code_q    <= lk_code;
                            shift_q   <= lk_upper;
                            frame_idx <= '0;
                            bit_idx   <= '0;
                            cnt       <= '0;
                            ps2_data  <= 1'b0;
                            state     <= S_BIT_HI;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_BIT_HI: begin
                    if (cnt == HALF_TC) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b0;
                        state   <= S_BIT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BIT_LO: begin
                    if (cnt == HALF_TC) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_data <= 1'b1;
                            state    <= S_GAP;
                        end else begin
                            bit_idx  <= next_bit;
                            ps2_data <= frame_word[next_bit];
                            state    <= S_BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_TC) begin
                        cnt <= '0;
                        if (last_frame) begin
                            state <= S_IDLE;
                        end else begin
                            frame_idx <= frame_idx + 3'd1;
                            bit_idx   <= '0;
                            ps2_data  <= 1'b0;
                            state     <= S_BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
module tb_ascii_ps2_tx;

    localparam int HALF  = 4;
    localparam int GAP   = 8;
    localparam int FRAME = 22 * HALF + GAP;

    logic clk = 1'b0;
    logic clrn;
    logic ps2_clk;
    logic ps2_data;
    logic busy;
    logic tx_done;
    logic err;

    int checks = 0;
    int errors = 0;

    ascii_ps2_tx_if bus();

    ascii_ps2_tx #(.HALF(HALF), .GAP(GAP)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .bus      (bus),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .tx_done  (tx_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Host-side receiver: samples ps2_data on every ps2_clk falling edge
    logic [10:0] rx_q[$];
    logic [10:0] rx_sh = '0;
    int          rx_nb = 0;
    int          fall_cnt = 0;
    logic        prev_clk = 1'b1;

    always @(negedge clk) begin
        prev_clk <= ps2_clk;
        if (busy !== 1'b1) begin
            rx_nb <= 0;
        end else if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            fall_cnt <= fall_cnt + 1;
            rx_sh    <= {ps2_data, rx_sh[10:1]};
            if (rx_nb == 10) begin
                rx_q.push_back({ps2_data, rx_sh[10:1]});
                rx_nb <= 0;
            end else begin
                rx_nb <= rx_nb + 1;
            end
        end
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents ch for one acceptance edge; returns at the negedge of cycle 1.
    task automatic send_char(input logic [7:0] ch, input bit hold, input logic [7:0] next_ch);
        @(negedge clk);
        chk("pre_send_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.ascii    = ch;
        @(posedge clk);
        @(negedge clk);
        if (hold) bus.ascii = next_ch;
        else      bus.in_valid = 1'b0;
    endtask

    // From the negedge of cycle 1, runs until tx_done or the budget expires.
    task automatic wait_done(input int budget, output int done_cyc, output int busy_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= budget; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int bc;
        int f0;
        int nrdy;
        int nerr;

        clrn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.ascii    = 8'h00;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        chk("rst_ps2_clk",  {31'd0, ps2_clk},      32'd1);
        chk("rst_ps2_data", {31'd0, ps2_data},     32'd1);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_busy",     {31'd0, busy},         32'd0);
        chk("rst_tx_done",  {31'd0, tx_done},      32'd0);
        chk("rst_err",      {31'd0, err},          32'd0);

        // 2: 'a' -> 1C F0 1C
        send_char(8'h61, 1'b0, 8'h00);
        chk("a_cyc1_busy",  {31'd0, busy},         32'd1);
        chk("a_cyc1_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("a_cyc1_clk",   {31'd0, ps2_clk},      32'd1);
        chk("a_cyc1_start", {31'd0, ps2_data},     32'd0);
        wait_done(1000, dc, bc);
        chk("a_done_cycle", dc, 3 * FRAME);
        chk("a_busy_len",   bc, 3 * FRAME);
        chk("a_nframes", rx_q.size(), 3);
        chk("a_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h1C, 1'b0)});
        chk("a_frame1", {21'd0, rx_q[1]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("a_frame2", {21'd0, rx_q[2]}, {21'd0, mk(8'h1C, 1'b0)});
        @(negedge clk);
        chk("a_after_ready",   {31'd0, bus.in_ready}, 32'd1);
        chk("a_after_busy",    {31'd0, busy},         32'd0);
        chk("a_after_tx_done", {31'd0, tx_done},      32'd0);
        rx_q.delete();

        // 3: 'A' -> 12 1C F0 1C F0 12
        send_char(8'h41, 1'b0, 8'h00);
        wait_done(2000, dc, bc);
        chk("A_done_cycle", dc, 6 * FRAME);
        chk("A_busy_len",   bc, 6 * FRAME);
        chk("A_nframes", rx_q.size(), 6);
        chk("A_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h12, 1'b1)});
        chk("A_frame1", {21'd0, rx_q[1]}, {21'd0, mk(8'h1C, 1'b0)});
        chk("A_frame2", {21'd0, rx_q[2]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("A_frame3", {21'd0, rx_q[3]}, {21'd0, mk(8'h1C, 1'b0)});
        chk("A_frame4", {21'd0, rx_q[4]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("A_frame5", {21'd0, rx_q[5]}, {21'd0, mk(8'h12, 1'b1)});
        @(negedge clk);
        chk("A_after_ready", {31'd0, bus.in_ready}, 32'd1);
        rx_q.delete();

        // 4: '~' unsupported
        f0 = fall_cnt;
        send_char(8'h7E, 1'b0, 8'h00);
        chk("tilde_err",   {31'd0, err},          32'd1);
        chk("tilde_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("tilde_busy",  {31'd0, busy},         32'd0);
        nrdy = 0;
        nerr = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) nrdy++;
            if (err !== 1'b0) nerr++;
        end
        chk("tilde_falls",     fall_cnt - f0, 0);
        chk("tilde_not_ready", nrdy, 0);
        chk("tilde_err_once",  nerr, 0);
        chk("tilde_nframes",   rx_q.size(), 0);

        // 5: '5' with 0Ah held valid throughout
        send_char(8'h35, 1'b1, 8'h0A);
        wait_done(1000, dc, bc);
        chk("five_done_cycle", dc, 3 * FRAME);
        chk("five_nframes", rx_q.size(), 3);
        chk("five_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h2E, 1'b1)});
        chk("five_frame1", {21'd0, rx_q[1]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("five_frame2", {21'd0, rx_q[2]}, {21'd0, mk(8'h2E, 1'b1)});
        rx_q.delete();
        @(negedge clk);
        chk("lf_gap_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("lf_gap_busy",  {31'd0, busy},         32'd0);
        @(negedge clk);
        chk("lf_accept_busy",  {31'd0, busy},         32'd1);
        chk("lf_accept_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        wait_done(1000, dc, bc);
        chk("lf_done_cycle", dc, 3 * FRAME);
        chk("lf_nframes", rx_q.size(), 3);
        chk("lf_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h5A, 1'b1)});
        chk("lf_frame1", {21'd0, rx_q[1]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("lf_frame2", {21'd0, rx_q[2]}, {21'd0, mk(8'h5A, 1'b1)});
        @(negedge clk);
        rx_q.delete();

        // 6: reset during bit 4 (low phase) of the F0 frame of 'z'
        send_char(8'h7A, 1'b0, 8'h00);
        repeat (FRAME + 8 * 4 + 5) @(negedge clk);
        chk("z_pre_clk",  {31'd0, ps2_clk},  32'd0);
        chk("z_pre_data", {31'd0, ps2_data}, 32'd0);
        chk("z_pre_busy", {31'd0, busy},     32'd1);
        clrn = 1'b0;
        @(negedge clk);
        chk("z_rst_clk",   {31'd0, ps2_clk},      32'd1);
        chk("z_rst_data",  {31'd0, ps2_data},     32'd1);
        chk("z_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("z_rst_busy",  {31'd0, busy},         32'd0);
        chk("z_nframes", rx_q.size(), 1);
        chk("z_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h1A, 1'b0)});
        clrn = 1'b1;
        rx_q.delete();
        repeat (3) @(negedge clk);
        chk("z_idle_clk", {31'd0, ps2_clk}, 32'd1);

        send_char(8'h62, 1'b0, 8'h00);
        wait_done(1000, dc, bc);
        chk("b_done_cycle", dc, 3 * FRAME);
        chk("b_nframes", rx_q.size(), 3);
        chk("b_frame0", {21'd0, rx_q[0]}, {21'd0, mk(8'h32, 1'b0)});
        chk("b_frame1", {21'd0, rx_q[1]}, {21'd0, mk(8'hF0, 1'b1)});
        chk("b_frame2", {21'd0, rx_q[2]}, {21'd0, mk(8'h32, 1'b0)});
        @(negedge clk);
        chk("b_after_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
